mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, max consecutive LSB grants while ic_req is pending before IC is forced.
REQ-002 Parameter: IO_BASE, default 32'h00030000, IO space starts here (addr >= IO_BASE is IO).
REQ-003 clk_in  in  1  single clock, rising edge.
REQ-004 rst_in  in  1  asynchronous, active-low reset.
REQ-005 rdy_in  in  1  global enable; low freezes all state.
REQ-006 ic_req  in  1 / ic_addr  in  32: ICache fetch request, held until ic_valid.
REQ-007 ic_valid  out  1 / ic_data  out  32: fetch result, valid for one cycle.
REQ-008 lsb_req  in  1 / lsb_lors  in  1 (0 load, 1 store) / lsb_op  in  6 / lsb_addr  in  32 / lsb_wdata  in  32: LSB request, held until lsb_valid.
REQ-009 lsb_valid  out  1 / lsb_rdata  out  32: LSB completion, one-cycle pulse; rdata meaningful for loads only.
REQ-010 rob_clear  in  1: pipeline flush.
REQ-011 io_buffer_full  in  1: UART buffer full.
REQ-012 mc_req  out  1 / mc_wr  out  1 / mc_op  out  6 / mc_addr  out  32 / mc_wdata  out  32: one-cycle issue to the byte-serial memory controller.
REQ-013 mc_done  in  1 / mc_rdata  in  32: controller completion strobe and assembled, extended data.

Function
REQ-014 Four states: IDLE, BUSY_IC, BUSY_LSB, RESP; state changes only on edges with rdy_in=1.
REQ-015 IDLE grant, in priority order:
- No grant if rob_clear=1.
- Grant IC if ic_req=1 and starve_cnt==STARVE_MAX.
- Grant LSB if lsb_req=1, unless it is a store with lsb_addr>=IO_BASE and io_buffer_full=1.
- Otherwise grant IC if ic_req=1.
REQ-016 A blocked IO store does not block an IC grant in the same cycle.
REQ-017 On grant, capture requester fields and register the matching mc_* outputs; drive mc_req=1 for exactly the next cycle.
- IC grant: mc_wr=0, mc_op=LW.
- LSB grant: mc_wr=lsb_lors, mc_op=lsb_op.
REQ-018 After a grant, enter BUSY_IC or BUSY_LSB and wait for mc_done; mc_done is ignored in IDLE and RESP.
REQ-019 On mc_done in BUSY_*, register mc_rdata into ic_data or lsb_rdata, pulse the matching valid for one cycle, and enter RESP.
REQ-020 RESP always returns to IDLE next cycle without granting (dead cycle that lets requesters drop req).
REQ-021 Minimum grant-to-valid latency: 2 cycles (grant edge T, mc_req in cycle T+1, mc_done sampled at T+1 earliest, valid in cycle T+2).
REQ-022 starve_cnt is 3 bits, reset 0:
- +1 on each LSB grant while ic_req=1, saturating at STARVE_MAX.
- Cleared to 0 on any IC grant.
- Cleared to 0 in IDLE when ic_req=0.
REQ-023 rob_clear during BUSY_IC, or BUSY_LSB with a load, sets a cancel flag.
REQ-024 On mc_done with the cancel flag set: no valid pulse, data outputs unchanged, flag cleared, go directly to IDLE.
REQ-025 rob_clear never cancels an in-flight store; the store completes with lsb_valid=1.
REQ-026 rob_clear in RESP does not retract a pulse already asserted.
REQ-027 ic_valid and lsb_valid are never high in the same cycle.
REQ-028 At most one mc transaction is outstanding.
REQ-029 With rdy_in=0, all registers hold, including mc_req and the valid outputs.

Reset
REQ-030 rst_in low asynchronously forces IDLE; cancel=0; starve_cnt=0; all outputs 0.
REQ-031 Reset applies regardless of rdy_in; any in-flight transaction is abandoned with no valid pulse.
REQ-032 The first grant occurs no earlier than the first rising edge after rst_in deasserts.

Verification
REQ-033 Load: lsb_req load LW to 0x100, mc_done two cycles after mc_req with mc_rdata=0xDEADBEEF -> lsb_valid=1 for one cycle with lsb_rdata=0xDEADBEEF, then one RESP cycle, then IDLE.
REQ-034 Starvation: ic_req and lsb_req held high, STARVE_MAX=4 -> grants LSB x4, then IC, then LSB; ic_valid and lsb_valid never coincide.
REQ-035 IO gating: store to 0x30000 with io_buffer_full=1 and ic_req=1 -> IC granted and no LSB mc_req; after io_buffer_full drops, the store issues with mc_wr=1 and mc_addr=0x30000.
REQ-036 Flush: rob_clear pulsed in BUSY_LSB (load) -> mc_done produces no lsb_valid and the arbiter returns to IDLE; same stimulus on a store SW -> lsb_valid=1.
REQ-037 Freeze: rdy_in=0 for 5 cycles during BUSY_IC with mc_done=1 -> no state change; after rdy_in=1, ic_valid pulses once.
REQ-038 Async reset: rst_in low mid-BUSY_LSB between edges -> all outputs 0 immediately; no valid pulse after release.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates ICache and LSB accesses onto a single-outstanding
//            memory controller, with IO back-pressure, starvation guard and
//            flush cancellation.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int          STARVE_MAX = 4,
    parameter logic [31:0] IO_BASE    = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,

    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_data,

    input  logic        lsb_req,
    input  logic        lsb_lors,
    input  logic [5:0]  lsb_op,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_valid,
    output logic [31:0] lsb_rdata,

    input  logic        rob_clear,
    input  logic        io_buffer_full,

    output logic        mc_req,
    output logic        mc_wr,
    output logic [5:0]  mc_op,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);

    localparam logic [5:0] c_OP_LW         = 6'd2;
    localparam logic [2:0] c_STARVE_MAX    = 3'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BUSY_IC  = 2'd1,
        S_BUSY_LSB = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t     r_state;
    logic [2:0] r_starve_cnt;
    logic       r_cancel;
    logic       r_is_store;

    logic w_io_blocked;
    logic w_force_ic;
    logic w_lsb_ok;
    logic w_grant_ic;
    logic w_grant_lsb;

    // A blocked IO store simply drops out of the running, letting IC win.
    assign w_io_blocked = lsb_lors && (lsb_addr >= IO_BASE) && io_buffer_full;
    assign w_force_ic   = ic_req && (r_starve_cnt == c_STARVE_MAX);
    assign w_lsb_ok     = lsb_req && !w_io_blocked;
    assign w_grant_ic   = !rob_clear && (w_force_ic || (ic_req && !w_lsb_ok));
    assign w_grant_lsb  = !rob_clear && !w_force_ic && w_lsb_ok;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 3'd0;
            r_cancel     <= 1'b0;
            r_is_store   <= 1'b0;
            ic_valid     <= 1'b0;
            ic_data      <= 32'd0;
            lsb_valid    <= 1'b0;
            lsb_rdata    <= 32'd0;
            mc_req       <= 1'b0;
            mc_wr        <= 1'b0;
            mc_op        <= 6'd0;
            mc_addr      <= 32'd0;
            mc_wdata     <= 32'd0;
        end else if (rdy_in) begin
            mc_req    <= 1'b0;
            ic_valid  <= 1'b0;
            lsb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!ic_req) begin
                        r_starve_cnt <= 3'd0;
                    end
                    if (w_grant_ic) begin
                        r_state      <= S_BUSY_IC;
                        r_starve_cnt <= 3'd0;
                        mc_req       <= 1'b1;
                        mc_wr        <= 1'b0;
                        mc_op        <= c_OP_LW;
                        mc_addr      <= ic_addr;
                        mc_wdata     <= 32'd0;
                    end else if (w_grant_lsb) begin
                        r_state    <= S_BUSY_LSB;
                        r_is_store <= lsb_lors;
                        mc_req     <= 1'b1;
                        mc_wr      <= lsb_lors;
                        mc_op      <= lsb_op;
                        mc_addr    <= lsb_addr;
                        mc_wdata   <= lsb_wdata;
                        if (ic_req && (r_starve_cnt < c_STARVE_MAX)) begin
                            r_starve_cnt <= r_starve_cnt + 3'd1;
                        end
                    end
                end
                S_BUSY_IC: begin
                    if (mc_done) begin
                        if (r_cancel) begin
                            r_cancel <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            ic_data  <= mc_rdata;
                            ic_valid <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end else if (rob_clear) begin
                        r_cancel <= 1'b1;
                    end
                end
                S_BUSY_LSB: begin
                    if (mc_done) begin
                        if (r_cancel) begin
                            r_cancel <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            lsb_rdata <= mc_rdata;
                            lsb_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end
                    end else if (rob_clear && !r_is_store) begin
                        // Stores are architecturally committed; only loads are squashed.
                        r_cancel <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
